// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size codes,
// FSM states, latched request bundle and lane helpers.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_req_t;

    function automatic logic [3:0] byte_en_f(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            LSU_B, LSU_BU: be = 4'b0001 << off;
            LSU_H, LSU_HU: be = 4'b0011 << off;
            LSU_W:         be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_replicate_f(
        input logic [2:0]  funct3,
        input logic [31:0] wdata
    );
        logic [31:0] d;
        d = wdata;
        case (funct3)
            LSU_B, LSU_BU: d = {4{wdata[7:0]}};
            LSU_H, LSU_HU: d = {2{wdata[15:0]}};
            default:       d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: shift read word down by byte offset, truncate to
// access size, then sign/zero extend. Ports: rd_data, offset, funct3 -> data.
module lsu_load_align (
    input  logic [31:0] rd_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    import lsu_pkg::*;

    logic [31:0] sh;

    assign sh = rd_data >> {offset, 3'b000};

    always_comb begin
        data = sh;
        case (funct3)
            LSU_B:   data = {{24{sh[7]}}, sh[7:0]};
            LSU_BU:  data = {24'h0, sh[7:0]};
            LSU_H:   data = {{16{sh[15]}}, sh[15:0]};
            LSU_HU:  data = {16'h0, sh[15:0]};
            default: data = sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data memory initiator: one load/store at a time, word-aligned access,
// fault detection. Ports: req_* from execute, resp_* back, mem_* to memory.
module load_store_unit #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_byte_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);
    import lsu_pkg::*;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    lsu_state_e  state;
    lsu_state_e  state_n;
    lsu_req_t    req;
    logic [1:0]  cnt;
    logic        illegal;
    logic        misaligned;
    logic        fault;
    logic [31:0] load_data;

    // Illegal wins over misaligned; stores have no unsigned sizes.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (req_funct3)
            LSU_B:   illegal = 1'b0;
            LSU_BU:  illegal = req_we;
            LSU_H:   misaligned = req_addr[0];
            LSU_HU: begin
                illegal    = req_we;
                misaligned = req_addr[0];
            end
            LSU_W:   misaligned = |req_addr[1:0];
            default: illegal = 1'b1;
        endcase
    end

    assign fault = illegal | misaligned;

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_n = fault ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: state_n = req.we ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (cnt == 2'd0) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    lsu_load_align u_align (
        .rd_data (mem_rd_data),
        .offset  (req.off),
        .funct3  (req.funct3),
        .data    (load_data)
    );

    // Memory strobes and response are registered so the ACCESS cycle
    // drives memory straight from flops; reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req             <= '0;
            cnt             <= '0;
            mem_addr        <= '0;
            mem_wr_data     <= '0;
            mem_byte_en     <= '0;
            mem_wr_en       <= 1'b0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
            resp_illegal    <= 1'b0;
        end else begin
            mem_wr_en   <= 1'b0;
            mem_byte_en <= 4'b0000;
            resp_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req.we          <= req_we;
                        req.funct3      <= req_funct3;
                        req.off         <= req_addr[1:0];
                        resp_data       <= '0;
                        resp_illegal    <= illegal;
                        resp_misaligned <= misaligned & ~illegal;
                        resp_valid      <= fault;
                        if (!fault) begin
                            mem_addr    <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_byte_en <= byte_en_f(req_funct3, req_addr[1:0]);
                            mem_wr_en   <= req_we;
                            if (req_we) begin
                                mem_wr_data <= wdata_replicate_f(req_funct3, req_wdata);
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    if (req.we) begin
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= LAT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) begin
                        resp_data  <= load_data;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
